cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
- Sequences the 8-bit single-cycle microprocessor core by generating its reset pulse and per-cycle clock enable.
- Supports free-run, single-step, halt-opcode stop and one PC breakpoint.
- Sits between the board buttons/switches and the core; watches core pc and the IMEM instruction bus.
- Exposes an executed-instruction count for the seven-segment display path.

Parameters:
- RST_CYCLES, 4, number of cycles core_reset stays high after controller reset release (1..15).
- HALT_OPCODE, 8'hFF, instruction encoding that stops RUN.
- CNT_W, 16, width of instr_count.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low controller reset.
- run_btn  in  1  raw run/stop toggle button; asynchronous input.
- step_btn  in  1  raw single-step button; asynchronous input.
- bp_en  in  1  breakpoint enable (static switch).
- bp_addr  in  8  breakpoint PC value.
- pc  in  8  current core PC (pcc).
- instruction  in  8  instruction at pc from IMEM.
- core_reset  out  1  active-high reset to core.
- cpu_en  out  1  core clock enable; the core updates PC/registers only when high.
- halted  out  1  high in HALT or BREAK (drives led).
- instr_count  out  CNT_W  count of cycles with cpu_en high.
- state  out  3  current FSM state encoding.

Behaviour:
- reset low (async):
  - state=RESET, core_reset=1, cpu_en=0, halted=0, instr_count=0.
  - Reset counter=0, button synchronisers cleared, bp_skip=0.
- Button conditioning:
  - Each button passes through a 2-FF synchroniser, then a rising-edge detect register.
  - The edge pulse is one cycle wide.
  - The FSM acts on the 3rd rising clk edge after the button is first sampled high.
  - Holding a button produces exactly one event.
- stop_cond = (instruction==HALT_OPCODE) | (bp_en & pc==bp_addr & ~bp_skip). Combinational.
- cpu_en = (state==RUN & ~stop_cond) | (state==STEP). Combinational from registered state; no added latency.
- States: RESET=0, HALT=1, RUN=2, STEP=3, BREAK=4.
- RESET:
  - core_reset=1, cpu_en=0.
  - Counter increments each cycle; when counter==RST_CYCLES-1, go to HALT.
  - core_reset is therefore high for exactly RST_CYCLES cycles after reset rises.
- HALT:
  - halted=1.
  - run_edge -> RUN.
  - step_edge -> STEP, unless instruction==HALT_OPCODE (step ignored, stay HALT).
- RUN:
  - Checked in priority order:
    - run_edge -> HALT (the current cycle's cpu_en still follows the formula).
    - instruction==HALT_OPCODE -> HALT.
    - breakpoint match (bp_en & pc==bp_addr & ~bp_skip) -> BREAK.
    - otherwise stay in RUN.
  - step_edge is ignored in RUN.
- STEP:
  - cpu_en=1 for exactly this one cycle; next state HALT.
  - Breakpoint is ignored; button edges are ignored.
- BREAK:
  - halted=1.
  - run_edge -> RUN and set bp_skip=1.
  - step_edge -> STEP.
- bp_skip:
  - Cleared on the first cycle in RUN with cpu_en=1.
  - Also cleared whenever bp_en=0.
  - Purpose: resuming from a breakpoint does not re-trigger on the same PC.
- Simultaneous run_edge and step_edge: run_edge wins; step_edge is discarded.
- instr_count increments on every edge where cpu_en=1 and saturates at all-ones (no wrap).
- core_reset=0 in every state except RESET.
- Reset mid-operation: all state returns to RESET immediately, and the RST_CYCLES sequence reruns.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding constants (RESET..BREAK, 3 bits);
  - HALT_OPCODE default;
  - opcode field constants reused by the core decoder.
- One sub-module, btn_sync_edge (2-FF sync + rising-edge pulse, async active-low reset), instantiated for run_btn and step_btn.

Test Plan:
- Release reset at t0 with RST_CYCLES=4 -> core_reset high for exactly 4 cycles, state RESET->HALT, cpu_en=0, instr_count=0.
- From HALT, pulse run_btn; IMEM holds no 8'hFF until pc=8'h05 -> cpu_en high for 5 cycles, state HALT at pc=5, instr_count=5, halted=1.
- From HALT at pc=8'h02, hold step_btn high 10 cycles -> exactly one cpu_en pulse, pc=8'h03, instr_count+1, state back to HALT.
- bp_en=1, bp_addr=8'h03, run -> BREAK with pc=3 and cpu_en=0; press run -> execution resumes past pc=3 without re-break; later reaching pc=3 again breaks.
- Assert run_btn and step_btn edges in the same cycle from HALT -> state RUN, no STEP; then drop reset low mid-RUN -> cpu_en=0 and core_reset=1 immediately, instr_count=0.
- Force instr_count to 16'hFFFE and run 4 cycles -> count holds at 16'hFFFF.

Source files
------------

// File: rtl/cpu_run_controller_pkg.sv
// rtl/cpu_run_controller_pkg.sv - shared state encoding and opcode constants for the run controller and core
// Contents: state_t (controller FSM encoding), HALT_OPCODE_DEF, opcode field bounds used by the core decoder.
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 8;

  // Default encoding that stops free-run; also decoded by the core as a no-op.
  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 8'hFF;

  // Opcode occupies the upper nibble of an instruction; the core decoder shares these bounds.
  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_HALT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  function automatic logic [OPC_HI-OPC_LO:0] opcode_field(input logic [OPCODE_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// rtl/cpu_run_controller_if.sv - controller <-> core sequencing bus
// Signals: pc (core PC), instruction (IMEM word at pc), core_reset (active-high core reset), cpu_en (core clock enable).
// Modports: master = run controller side, slave = core side.
interface cpu_run_controller_if;
  import cpu_ctrl_pkg::*;

  logic [OPCODE_W-1:0] pc;
  logic [OPCODE_W-1:0] instruction;
  logic                core_reset;
  logic                cpu_en;

  modport master (output core_reset, output cpu_en, input pc, input instruction);
  modport slave  (input core_reset, input cpu_en, output pc, output instruction);

endinterface

// File: rtl/cpu_run_controller_btn_sync_edge.sv
// rtl/cpu_run_controller_btn_sync_edge.sv - button synchroniser with one-cycle rising-edge pulse
// Ports: clk, rst_n (async active-low), btn (raw async button), pulse (one-cycle rising-edge event).
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      prev <= sync[1];
    end
  end

  // High on the cycle after the second sync stage first sees the button,
  // so the consumer acts on the third clock edge after the first sample.
  assign pulse = sync[1] & ~prev;

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - reset/run/step/halt/breakpoint sequencer for the 8-bit core
// Ports: clk; reset (async active-low); run_btn, step_btn (raw buttons); bp_en, bp_addr (breakpoint);
//        core (master modport: pc, instruction in; core_reset, cpu_en out);
//        halted (HALT or BREAK); instr_count (saturating count of enabled cycles); state (FSM encoding).
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int                  RST_CYCLES  = 4,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int                  CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_btn,
  input  logic                step_btn,
  input  logic                bp_en,
  input  logic [OPCODE_W-1:0] bp_addr,
  cpu_run_controller_if.master core,
  output logic                halted,
  output logic [CNT_W-1:0]    instr_count,
  output logic [2:0]          state
);

  state_t     st;
  logic [3:0] rst_cnt;
  logic       bp_skip;
  logic       run_edge;
  logic       step_edge;
  logic       is_halt;
  logic       bp_hit;
  logic       stop_cond;

  btn_sync_edge u_run_sync  (.clk(clk), .rst_n(reset), .btn(run_btn),  .pulse(run_edge));
  btn_sync_edge u_step_sync (.clk(clk), .rst_n(reset), .btn(step_btn), .pulse(step_edge));

  assign is_halt   = (core.instruction == HALT_OPCODE);
  assign bp_hit    = bp_en & (core.pc == bp_addr) & ~bp_skip;
  assign stop_cond = is_halt | bp_hit;

  // The enable follows the registered state directly so the stopping
  // instruction is never executed.
  assign core.cpu_en = ((st == ST_RUN) & ~stop_cond) | (st == ST_STEP);
  assign state       = st;

  // core_reset and halted are updated alongside each transition so they are
  // registered copies of the next state's decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st              <= ST_RESET;
      rst_cnt         <= 4'd0;
      core.core_reset <= 1'b1;
      halted          <= 1'b0;
    end else begin
      case (st)
        ST_RESET: begin
          if (rst_cnt == 4'(RST_CYCLES - 1)) begin
            st              <= ST_HALT;
            core.core_reset <= 1'b0;
            halted          <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 4'd1;
          end
        end
        ST_HALT: begin
          // run wins over a simultaneous step; stepping onto a halt opcode is refused
          if (run_edge) begin
            st     <= ST_RUN;
            halted <= 1'b0;
          end else if (step_edge && !is_halt) begin
            st     <= ST_STEP;
            halted <= 1'b0;
          end
        end
        ST_RUN: begin
          if (run_edge || is_halt) begin
            st     <= ST_HALT;
            halted <= 1'b1;
          end else if (bp_hit) begin
            st     <= ST_BREAK;
            halted <= 1'b1;
          end
        end
        ST_STEP: begin
          st     <= ST_HALT;
          halted <= 1'b1;
        end
        ST_BREAK: begin
          if (run_edge) begin
            st     <= ST_RUN;
            halted <= 1'b0;
          end else if (step_edge) begin
            st     <= ST_STEP;
            halted <= 1'b0;
          end
        end
        default: begin
          st              <= ST_RESET;
          rst_cnt         <= 4'd0;
          core.core_reset <= 1'b1;
          halted          <= 1'b0;
        end
      endcase
    end
  end

  // bp_skip lets a resume from BREAK execute the breakpoint PC once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_skip <= 1'b0;
    end else if (!bp_en) begin
      bp_skip <= 1'b0;
    end else if (st == ST_BREAK && run_edge) begin
      bp_skip <= 1'b1;
    end else if (st == ST_RUN && core.cpu_en) begin
      bp_skip <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (core.cpu_en && (instr_count != {CNT_W{1'b1}})) begin
      instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - self-checking bench for cpu_run_controller with a behavioural core and IMEM
module tb_cpu_run_controller;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run_btn, step_btn, bp_en;
  logic [7:0]  bp_addr;
  logic        halted;
  logic [15:0] instr_count;
  logic [2:0]  state;

  logic        reset2, run2, step2, bp_en2;
  logic [7:0]  bp_addr2;
  logic        halted2;
  logic [2:0]  count2;
  logic [2:0]  state2;

  logic [7:0]  imem [256];
  int          errors = 0;
  int          checks = 0;
  int          en_seen = 0;

  always #5 clk = ~clk;

  cpu_run_controller_if core_bus ();
  cpu_run_controller_if core_sat ();

  cpu_run_controller u_dut (
    .clk(clk), .reset(reset), .run_btn(run_btn), .step_btn(step_btn),
    .bp_en(bp_en), .bp_addr(bp_addr), .core(core_bus),
    .halted(halted), .instr_count(instr_count), .state(state)
  );

  cpu_run_controller #(.RST_CYCLES(1), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset2), .run_btn(run2), .step_btn(step2),
    .bp_en(bp_en2), .bp_addr(bp_addr2), .core(core_sat),
    .halted(halted2), .instr_count(count2), .state(state2)
  );

  // Behavioural core: PC advances only on enabled cycles.
  always @(posedge clk) begin
    if (core_bus.core_reset) core_bus.pc <= 8'h00;
    else if (core_bus.cpu_en) core_bus.pc <= core_bus.pc + 8'h01;
    if (core_sat.core_reset) core_sat.pc <= 8'h00;
    else if (core_sat.cpu_en) core_sat.pc <= core_sat.pc + 8'h01;
    if (core_bus.cpu_en) en_seen <= en_seen + 1;
  end
  assign core_bus.instruction = imem[core_bus.pc];
  assign core_sat.instruction = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instructions executed from 'start' before free-run stops (halt opcode or breakpoint).
  function automatic int cycles_to_stop(input int start, input bit use_bp, input int bp, input bit skip);
    int p = start;
    bit sk = skip;
    for (int n = 0; n < 1000; n++) begin
      if (imem[p[7:0]] == 8'hFF) return n;
      if (use_bp && p == bp && !sk) return n;
      sk = 1'b0;
      p = (p + 1) % 256;
    end
    return 1000;
  endfunction

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int i = 0;
    while (state !== s && i < budget) begin
      tick();
      i++;
    end
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL %s: state=%0d want %0d within %0d cycles", tag, state, s, budget);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0; run_btn = 1'b0; step_btn = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    wait_state(ST_HALT, 20, "reset_to_halt");
  endtask

  task automatic test_reset();
    int n = 0;
    repeat (3) tick();
    checks += 5;
    if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
    if (core_bus.core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset: got %b want 1", core_bus.core_reset); end
    if (core_bus.cpu_en !== 1'b0) begin errors++; $display("FAIL rst_cpu_en: got %b want 0", core_bus.cpu_en); end
    if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    if (instr_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", instr_count); end
    reset = 1'b1;
    while (core_bus.core_reset === 1'b1 && n < 20) begin n++; tick(); end
    checks += 4;
    if (n != 4) begin errors++; $display("FAIL rst_len: core_reset high %0d cycles want 4", n); end
    if (state !== 3'd1) begin errors++; $display("FAIL rst_then_halt: got %0d want 1", state); end
    if (halted !== 1'b1) begin errors++; $display("FAIL rst_halted_after: got %b want 1", halted); end
    if (instr_count !== 16'd0) begin errors++; $display("FAIL rst_count_after: got %0d want 0", instr_count); end
  endtask

  task automatic test_run_to_halt();
    int hp = $urandom_range(3, 9);
    int h  = $urandom_range(1, 3);
    int n, e0;
    logic [15:0] c0, c1;
    imem[hp] = 8'hFF;
    n  = cycles_to_stop(0, 1'b0, 0, 1'b0);
    e0 = en_seen; c0 = instr_count;
    run_btn = 1'b1;
    repeat (h) tick();
    run_btn = 1'b0;
    wait_state(ST_RUN, 10, "run_start");
    wait_state(ST_HALT, 400, "run_halt_opcode");
    checks += 4;
    if (core_bus.pc !== 8'(hp)) begin errors++; $display("FAIL run_pc: got %0d want %0d", core_bus.pc, hp); end
    if (instr_count !== 16'(c0 + n)) begin errors++; $display("FAIL run_count: got %0d want %0d", instr_count, c0 + n); end
    if (en_seen - e0 != n) begin errors++; $display("FAIL run_en_cycles: got %0d want %0d", en_seen - e0, n); end
    if (halted !== 1'b1) begin errors++; $display("FAIL run_halted: got %b want 1", halted); end
    // Step onto a halt opcode is refused.
    c1 = instr_count;
    step_btn = 1'b1; tick(); step_btn = 1'b0;
    repeat (6) tick();
    checks += 2;
    if (state !== 3'd1 || core_bus.pc !== 8'(hp)) begin errors++; $display("FAIL step_on_halt: state=%0d pc=%0d want 1/%0d", state, core_bus.pc, hp); end
    if (instr_count !== c1) begin errors++; $display("FAIL step_on_halt_count: got %0d want %0d", instr_count, c1); end
    imem[hp] = 8'($urandom_range(0, 254));
  endtask

  task automatic test_step_hold();
    int e0;
    logic [15:0] c0;
    reset_dut();
    for (int k = 0; k < 2; k++) begin
      step_btn = 1'b1; tick(); step_btn = 1'b0;
      repeat (5) tick();
    end
    checks++;
    if (core_bus.pc !== 8'h02) begin errors++; $display("FAIL step_pre_pc: got %0d want 2", core_bus.pc); end
    e0 = en_seen; c0 = instr_count;
    step_btn = 1'b1;
    repeat (10 + $urandom_range(0, 5)) tick();
    step_btn = 1'b0;
    repeat (5) tick();
    checks += 4;
    if (core_bus.pc !== 8'h03) begin errors++; $display("FAIL step_pc: got %0d want 3", core_bus.pc); end
    if (instr_count !== c0 + 16'd1) begin errors++; $display("FAIL step_count: got %0d want %0d", instr_count, c0 + 16'd1); end
    if (en_seen - e0 != 1) begin errors++; $display("FAIL step_en_pulses: got %0d want 1", en_seen - e0); end
    if (state !== 3'd1) begin errors++; $display("FAIL step_state: got %0d want 1", state); end
  endtask

  task automatic test_breakpoint();
    int bp = $urandom_range(2, 12);
    int n1, n2;
    logic [15:0] c0;
    reset_dut();
    bp_en = 1'b1; bp_addr = 8'(bp);
    n1 = cycles_to_stop(0, 1'b1, bp, 1'b0);
    run_btn = 1'b1; tick(); run_btn = 1'b0;
    wait_state(ST_RUN, 10, "bp_run_start");
    wait_state(ST_BREAK, 400, "bp_first_break");
    checks += 4;
    if (core_bus.pc !== 8'(bp)) begin errors++; $display("FAIL bp_pc: got %0d want %0d", core_bus.pc, bp); end
    if (core_bus.cpu_en !== 1'b0) begin errors++; $display("FAIL bp_cpu_en: got %b want 0", core_bus.cpu_en); end
    if (halted !== 1'b1) begin errors++; $display("FAIL bp_halted: got %b want 1", halted); end
    if (instr_count !== 16'(n1)) begin errors++; $display("FAIL bp_count: got %0d want %0d", instr_count, n1); end
    // Resume: must pass the breakpoint PC once, wrap round, and break there again.
    n2 = cycles_to_stop(bp, 1'b1, bp, 1'b1);
    run_btn = 1'b1; tick(); run_btn = 1'b0;
    wait_state(ST_RUN, 10, "bp_resume");
    wait_state(ST_BREAK, 600, "bp_second_break");
    checks += 2;
    if (core_bus.pc !== 8'(bp)) begin errors++; $display("FAIL bp_rebreak_pc: got %0d want %0d", core_bus.pc, bp); end
    if (instr_count !== 16'(n1 + n2)) begin errors++; $display("FAIL bp_rebreak_count: got %0d want %0d", instr_count, n1 + n2); end
    c0 = instr_count;
    step_btn = 1'b1; tick(); step_btn = 1'b0;
    repeat (6) tick();
    checks += 2;
    if (state !== 3'd1 || core_bus.pc !== 8'(bp + 1)) begin errors++; $display("FAIL bp_step: state=%0d pc=%0d want 1/%0d", state, core_bus.pc, bp + 1); end
    if (instr_count !== c0 + 16'd1) begin errors++; $display("FAIL bp_step_count: got %0d want %0d", instr_count, c0 + 16'd1); end
    bp_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit saw_run = 1'b0, saw_step = 1'b0;
    int n = 0;
    reset_dut();
    run_btn = 1'b1; step_btn = 1'b1; tick();
    run_btn = 1'b0; step_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (state === 3'd3) saw_step = 1'b1;
      if (state === 3'd2) saw_run = 1'b1;
      tick();
    end
    checks += 2;
    if (saw_step) begin errors++; $display("FAIL both_no_step: saw STEP state, want none"); end
    if (!saw_run || state !== 3'd2) begin errors++; $display("FAIL both_run: saw_run=%b state=%0d want 1/2", saw_run, state); end
    reset = 1'b0;
    #1;
    checks += 4;
    if (core_bus.cpu_en !== 1'b0) begin errors++; $display("FAIL midrst_cpu_en: got %b want 0", core_bus.cpu_en); end
    if (core_bus.core_reset !== 1'b1) begin errors++; $display("FAIL midrst_core_reset: got %b want 1", core_bus.core_reset); end
    if (instr_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", instr_count); end
    if (state !== 3'd0) begin errors++; $display("FAIL midrst_state: got %0d want 0", state); end
    tick();
    reset = 1'b1;
    while (core_bus.core_reset === 1'b1 && n < 20) begin n++; tick(); end
    checks++;
    if (n != 4) begin errors++; $display("FAIL midrst_rerun_len: got %0d want 4", n); end
  endtask

  task automatic test_saturation();
    int n = 0, i = 0;
    reset2 = 1'b1;
    while (core_sat.core_reset === 1'b1 && n < 20) begin n++; tick(); end
    checks++;
    if (n != 1) begin errors++; $display("FAIL sat_rst_len: got %0d want 1", n); end
    run2 = 1'b1; tick(); run2 = 1'b0;
    while (state2 !== 3'd2 && i < 10) begin tick(); i++; end
    checks++;
    if (state2 !== 3'd2) begin errors++; $display("FAIL sat_run_start: state=%0d want 2", state2); end
    repeat (5) tick();
    checks++;
    if (count2 !== 3'd5) begin errors++; $display("FAIL sat_count_mid: got %0d want 5", count2); end
    repeat (7) tick();
    checks += 2;
    if (count2 !== 3'd7) begin errors++; $display("FAIL sat_count_hold: got %0d want 7", count2); end
    if (core_sat.cpu_en !== 1'b1) begin errors++; $display("FAIL sat_still_running: cpu_en=%b want 1", core_sat.cpu_en); end
  endtask

  initial begin
    reset = 1'b0; run_btn = 1'b0; step_btn = 1'b0; bp_en = 1'b0; bp_addr = 8'h00;
    reset2 = 1'b0; run2 = 1'b0; step2 = 1'b0; bp_en2 = 1'b0; bp_addr2 = 8'h00;
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom_range(0, 254));
    test_reset();
    test_run_to_halt();
    test_step_hold();
    test_breakpoint();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
